// File: rtl/ins_fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// HALTED is only reachable when INS_FETCH_HALT_EN is defined.
package ins_fetch_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int INS_W_DEF  = 16;

    localparam logic [15:0] HALT_OPCODE = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } fetch_state_t;

    // One buffered instruction together with the address it came from.
    typedef struct packed {
        logic [INS_W_DEF-1:0]  ins;
        logic [ADDR_W_DEF-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/ins_fetch_skid.sv
// Two-entry FIFO holding returned instructions until decode pops them.
// A flush empties it in one edge and overrides any push or pop in that cycle.
module ins_fetch_skid #(
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] ent0;
    logic [DATA_W-1:0] ent1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0  <= '0;
            ent1  <= '0;
            count <= 2'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            // ent0 is always the head; a pop shifts ent1 forward.
            if (pop) begin
                if (count == 2'd2)
                    ent0 <= ent1;
                else if (push)
                    ent0 <= din;
                if (push && count == 2'd2)
                    ent1 <= din;
            end else if (push) begin
                if (count == 2'd0)
                    ent0 <= din;
                else
                    ent1 <= din;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign dout = ent0;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n && !flush)
            assert (!(push && !pop && count == 2'd2));
    end
`endif

endmodule

// File: rtl/ins_fetch_ctrl.sv
// Fetch sequencer: PC, run/idle FSM, issue credit and squash in front of a 1-cycle ROM.
// Define INS_FETCH_HALT_EN to stop fetching when HALT_OPCODE is returned.
module ins_fetch_ctrl
    import ins_fetch_pkg::*;
#(
    parameter int                 ADDR_W   = ADDR_W_DEF,
    parameter int                 INS_W    = INS_W_DEF,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] mem_add,
    input  logic [INS_W-1:0]  mem_ins,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [INS_W-1:0]  ins_out,
    output logic [ADDR_W-1:0] ins_pc,
    output logic              halt
);

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] issued_pc;
    logic              inflight;
    logic [1:0]        count;
    logic              pop, push, issue, squash, halt_push;

    assign mem_add   = pc;
    assign ins_valid = (count != 2'd0);
    assign pop       = ins_valid & ins_ready;

    // A return is dropped if a redirect lands on it or fetch has halted.
    assign squash = redirect_valid | (state == HALTED);
    assign push   = inflight & ~squash;

    // Credit: buffered + in-flight entries after this pop must leave room.
    assign issue = (state == RUN) && !redirect_valid &&
                   (({1'b0, count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));

`ifdef INS_FETCH_HALT_EN
    assign halt_push = push && (mem_ins == INS_W'(HALT_OPCODE));
    assign halt      = (state == HALTED);
`else
    assign halt_push = 1'b0;
    assign halt      = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        if (redirect_valid) begin
            state_nxt = fetch_en ? RUN : IDLE;
        end else begin
            case (state)
                IDLE:    if (halt_push) state_nxt = HALTED;
                         else if (fetch_en) state_nxt = RUN;
                RUN:     if (halt_push) state_nxt = HALTED;
                         else if (!fetch_en) state_nxt = IDLE;
                HALTED:  state_nxt = HALTED;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            issued_pc <= '0;
            inflight  <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= issue;
            if (redirect_valid)
                pc <= redirect_pc;
            else if (issue)
                pc <= pc + 1'b1;
            if (issue)
                issued_pc <= pc;
        end
    end

    ins_fetch_skid #(
        .DATA_W (INS_W + ADDR_W)
    ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   ({mem_ins, issued_pc}),
        .dout  ({ins_out, ins_pc}),
        .count (count)
    );

endmodule

// File: tb/tb_ins_fetch_ctrl.sv
// Directed bench for ins_fetch_ctrl: cycle table plus reset and halt sequences.
// ROM content is {8'h5A, addr} so instruction and PC mismatches are distinguishable.
module tb_ins_fetch_ctrl;
    import ins_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_pc = 8'h00;
    logic        ins_ready = 1'b0;
    logic [7:0]  mem_add;
    logic [15:0] mem_ins;
    logic        ins_valid;
    logic [15:0] ins_out;
    logic [7:0]  ins_pc;
    logic        halt;

    logic [15:0] rom [256];
    int          n_vec = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) mem_ins <= rom[mem_add];

    ins_fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .mem_add        (mem_add),
        .mem_ins        (mem_ins),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ins_valid      (ins_valid),
        .ins_ready      (ins_ready),
        .ins_out        (ins_out),
        .ins_pc         (ins_pc),
        .halt           (halt)
    );

    typedef struct {
        bit         fe;
        bit         rv;
        logic [7:0] rpc;
        bit         rdy;
        bit         ev;
        logic [7:0] epc;
        logic [7:0] emem;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [15:0] pat(input logic [7:0] a);
        return {8'h5A, a};
    endfunction

    function automatic vec_t mk(input bit fe, input bit rv, input logic [7:0] rpc, input bit rdy,
                                input bit ev, input logic [7:0] epc, input logic [7:0] emem);
        vec_t v;
        v.fe = fe; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.ev = ev; v.epc = epc; v.emem = emem;
        return v;
    endfunction

    task automatic drive(input bit fe, input bit rv, input logic [7:0] rpc, input bit rdy);
        fetch_en = fe; redirect_valid = rv; redirect_pc = rpc; ins_ready = rdy;
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic chk_entry(input string name, input int idx, input logic [15:0] ins, input logic [7:0] pc);
        fetch_entry_t e;
        e.ins = ins;
        e.pc  = pc;
        chk(name, idx, 32'({ins_out, ins_pc}), 32'(e));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = pat(8'(i));

        // stream, 5-cycle stall, redirect with stale data, redirect+pop and wrap, fetch_en drop, idle redirect
        tbl.push_back(mk(1, 0, 8'h00, 1, 0, 8'h00, 8'h00));  // 0
        tbl.push_back(mk(1, 0, 8'h00, 1, 0, 8'h00, 8'h00));
        tbl.push_back(mk(1, 0, 8'h00, 1, 0, 8'h00, 8'h01));
        tbl.push_back(mk(1, 0, 8'h00, 1, 1, 8'h00, 8'h02));
        tbl.push_back(mk(1, 0, 8'h00, 1, 1, 8'h01, 8'h03));
        tbl.push_back(mk(1, 0, 8'h00, 0, 1, 8'h02, 8'h04));  // 5
        tbl.push_back(mk(1, 0, 8'h00, 0, 1, 8'h02, 8'h04));
        tbl.push_back(mk(1, 0, 8'h00, 0, 1, 8'h02, 8'h04));
        tbl.push_back(mk(1, 0, 8'h00, 0, 1, 8'h02, 8'h04));
        tbl.push_back(mk(1, 0, 8'h00, 0, 1, 8'h02, 8'h04));
        tbl.push_back(mk(1, 0, 8'h00, 1, 1, 8'h02, 8'h04));  // 10
        tbl.push_back(mk(1, 0, 8'h00, 1, 1, 8'h03, 8'h05));
        tbl.push_back(mk(1, 0, 8'h00, 1, 1, 8'h04, 8'h06));
        tbl.push_back(mk(1, 1, 8'h40, 0, 1, 8'h05, 8'h07));
        tbl.push_back(mk(1, 0, 8'h00, 1, 0, 8'h00, 8'h40));
        tbl.push_back(mk(1, 0, 8'h00, 1, 0, 8'h00, 8'h41));  // 15
        tbl.push_back(mk(1, 0, 8'h00, 1, 1, 8'h40, 8'h42));
        tbl.push_back(mk(1, 0, 8'h00, 1, 1, 8'h41, 8'h43));
        tbl.push_back(mk(1, 1, 8'hFE, 1, 1, 8'h42, 8'h44));
        tbl.push_back(mk(1, 0, 8'h00, 1, 0, 8'h00, 8'hFE));
        tbl.push_back(mk(1, 0, 8'h00, 1, 0, 8'h00, 8'hFF));  // 20
        tbl.push_back(mk(1, 0, 8'h00, 1, 1, 8'hFE, 8'h00));
        tbl.push_back(mk(1, 0, 8'h00, 1, 1, 8'hFF, 8'h01));
        tbl.push_back(mk(1, 0, 8'h00, 1, 1, 8'h00, 8'h02));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 8'h01, 8'h03));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 8'h01, 8'h03));  // 25
        tbl.push_back(mk(0, 0, 8'h00, 1, 1, 8'h01, 8'h03));
        tbl.push_back(mk(0, 0, 8'h00, 1, 1, 8'h02, 8'h03));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 8'h03));
        tbl.push_back(mk(0, 1, 8'h80, 0, 0, 8'h00, 8'h03));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 8'h80));  // 30
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 8'h80));

        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", 0, 32'(ins_valid), 32'd0);
        chk_entry("rst_entry", 0, 16'h0000, 8'h00);
        chk("rst_mem_add", 0, 32'(mem_add), 32'h00);
        chk("rst_halt", 0, 32'(halt), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k].fe, tbl[k].rv, tbl[k].rpc, tbl[k].rdy);
            #1;
            chk("valid", k, 32'(ins_valid), 32'(tbl[k].ev));
            chk("mem_add", k, 32'(mem_add), 32'(tbl[k].emem));
            chk("halt", k, 32'(halt), 32'd0);
            if (tbl[k].ev)
                chk_entry("entry", k, pat(tbl[k].epc), tbl[k].epc);
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a running stream.
        drive(1, 0, 8'h00, 1);
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 0, 32'(ins_valid), 32'd0);
        chk_entry("midrst_entry", 0, 16'h0000, 8'h00);
        chk("midrst_mem_add", 0, 32'(mem_add), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int cyc;
            cyc = 0;
            #1;
            while (!ins_valid && cyc < 8) begin
                @(negedge clk);
                #1;
                cyc++;
            end
            chk("restart_latency", 0, 32'(cyc), 32'd3);
            chk_entry("restart_entry", 0, pat(8'h00), 8'h00);
            chk("restart_mem_add", 0, 32'(mem_add), 32'h02);
        end

`ifdef INS_FETCH_HALT_EN
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 0, 8'h00, 0);
        rom[3] = 16'hFFFF;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 8'h00, 1);
        repeat (5) @(negedge clk);
        #1;
        chk("halt_k5", 5, 32'(halt), 32'd0);
        chk_entry("halt_k5_entry", 5, pat(8'h02), 8'h02);
        @(negedge clk);
        #1;
        chk("halt_k6", 6, 32'(halt), 32'd1);
        chk("halt_k6_valid", 6, 32'(ins_valid), 32'd1);
        chk_entry("halt_k6_entry", 6, 16'hFFFF, 8'h03);
        @(negedge clk);
        #1;
        chk("halt_k7", 7, 32'(halt), 32'd1);
        chk("halt_k7_valid", 7, 32'(ins_valid), 32'd0);
        chk("halt_k7_mem_add", 7, 32'(mem_add), 32'h05);
        @(negedge clk);
        drive(1, 1, 8'h00, 1);
        #1;
        chk("halt_k8_valid", 8, 32'(ins_valid), 32'd0);
        @(negedge clk);
        drive(1, 0, 8'h00, 1);
        #1;
        chk("halt_k9", 9, 32'(halt), 32'd0);
        chk("halt_k9_mem_add", 9, 32'(mem_add), 32'h00);
        repeat (2) @(negedge clk);
        #1;
        chk("halt_k11_valid", 11, 32'(ins_valid), 32'd1);
        chk_entry("halt_k11_entry", 11, pat(8'h00), 8'h00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
